// File: rtl/inst_mem_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_pkg
// Shared definitions for the loadable instruction memory:
//   NOP_WORD_DEFAULT - word returned on a faulting fetch unless overridden
//   clog2()          - word-index width for a given array depth
//   slot_ctl_t       - control half of a fetch pipeline slot (valid, fault);
//                      the data half is sized by the instantiating module
// -----------------------------------------------------------------------------
package inst_mem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Smallest r with 2**r >= value. Bounded loop so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic valid;
    logic fault;
  } slot_ctl_t;

endpackage

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// DEPTH x DATA_W word storage with one synchronous write port and one
// synchronous read port. Contents are never reset and survive rst_ni; only the
// read-data register is cleared so the fetch output starts at zero.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i       read enable and word index; rdata_o holds when re_i=0
//   rdata_o            registered read data
// -----------------------------------------------------------------------------
module inst_mem_array #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_fetch.sv
// -----------------------------------------------------------------------------
// inst_mem_fetch
// Loadable instruction memory with a request/valid fetch pipeline of LATENCY
// cycles. Faults (misaligned or out-of-range) are decided at acceptance and
// return NOP_WORD without touching the array. Stall freezes every stage.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   req_i, addr_i, ready_o      fetch request / byte address / accept-ready
//   inst_o, inst_valid_o, fault_o  fetch result
//   stall_i                     consumer hold
//   ld_en_i, ld_addr_i, ld_data_i  loader write port (byte address)
// -----------------------------------------------------------------------------
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              fault_o,
  input  logic              stall_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i
);

  localparam int IDX_W = clog2(DEPTH);

  typedef struct packed {
    slot_ctl_t         ctl;
    logic [DATA_W-1:0] data;
  } slot_t;

  logic              accept;
  logic [ADDR_W-1:0] fetch_word;
  logic [ADDR_W-1:0] ld_word;
  logic              fetch_misaligned;
  logic              fetch_oor;
  logic              fetch_fault;
  logic              ld_in_range;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  slot_ctl_t         s1_ctl_q, s1_ctl_d;
  logic              s1_nop_q;
  slot_t             s1_slot;

  // A loader write takes the cycle, so there is never a same-edge read/write.
  assign ready_o = ~stall_i & ~ld_en_i;
  assign accept  = req_i & ready_o;

  // Compare the full word address against DEPTH so large addresses never alias.
  assign fetch_word       = {2'b00, addr_i[ADDR_W-1:2]};
  assign ld_word          = {2'b00, ld_addr_i[ADDR_W-1:2]};
  assign fetch_misaligned = |addr_i[1:0];
  assign fetch_oor        = fetch_word >= ADDR_W'(DEPTH);
  assign fetch_fault      = fetch_misaligned | fetch_oor;
  assign ld_in_range      = ld_word < ADDR_W'(DEPTH);
  assign rd_en            = accept & ~fetch_fault;

  inst_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ld_en_i & ld_in_range),
    .waddr_i (ld_addr_i[IDX_W+1:2]),
    .wdata_i (ld_data_i),
    .re_i    (rd_en),
    .raddr_i (addr_i[IDX_W+1:2]),
    .rdata_o (rd_data)
  );

  always_comb begin
    s1_ctl_d       = '0;
    s1_ctl_d.valid = accept;
    s1_ctl_d.fault = accept & fetch_fault;
  end

  // Stage 1: control bits beside the array's own read register. s1_nop_q only
  // changes on an accept so that bubbles keep showing the last result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_ctl_q <= '0;
      s1_nop_q <= 1'b0;
    end else if (!stall_i) begin
      s1_ctl_q <= s1_ctl_d;
      if (accept) s1_nop_q <= fetch_fault;
    end
  end

  always_comb begin
    s1_slot      = '0;
    s1_slot.ctl  = s1_ctl_q;
    s1_slot.data = s1_nop_q ? NOP_WORD : rd_data;
  end

  // Stages 2..LATENCY are pure delay; data only moves with a valid slot.
  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    slot_t slot;
    if (g == 0) begin : g_first
      assign slot = s1_slot;
    end else begin : g_delay
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slot <= '0;
        end else if (!stall_i) begin
          slot.ctl <= g_stage[g-1].slot.ctl;
          if (g_stage[g-1].slot.ctl.valid) slot.data <= g_stage[g-1].slot.data;
        end
      end
    end
  end

  assign inst_o       = g_stage[LATENCY-1].slot.data;
  assign inst_valid_o = g_stage[LATENCY-1].slot.ctl.valid;
  assign fault_o      = g_stage[LATENCY-1].slot.ctl.fault;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_fetch
// Drives two instances (LATENCY=1 and LATENCY=3) from the same inputs and
// compares both against a tick-indexed model: each accept is recorded at the
// count of non-stalled edges, and its result is due LATENCY ticks later.
// -----------------------------------------------------------------------------
module tb_inst_mem_fetch;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam int          HIST  = 4096;

  logic        clk = 1'b0;
  logic        rst_n, req, stall, ld_en;
  logic [31:0] addr, ld_addr, ld_data;

  logic        rdy1, v1, f1, rdy3, v3, f3;
  logic [31:0] inst1, inst3;

  always #5 clk = ~clk;

  inst_mem_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .ready_o(rdy1),
    .inst_o(inst1), .inst_valid_o(v1), .fault_o(f1), .stall_i(stall),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  inst_mem_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(3), .NOP_WORD(NOP)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .ready_o(rdy3),
    .inst_o(inst3), .inst_valid_o(v3), .fault_o(f3), .stall_i(stall),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem_m [DEPTH];
  logic        acc_v [HIST];
  logic        acc_f [HIST];
  logic [31:0] acc_d [HIST];
  logic [31:0] last_m [2];
  int          tick    = 0;
  int          floor_t = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k, input int lat, input logic [31:0] inst,
                           input logic v, input logic f);
    int   a;
    logic ev, ef;
    a  = tick - lat;
    ev = 1'b0;
    ef = 1'b0;
    if (a >= floor_t && a >= 0 && acc_v[a]) begin
      ev        = 1'b1;
      ef        = acc_f[a];
      last_m[k] = acc_d[a];
    end
    check($sformatf("valid_l%0d_t%0d", lat, tick), {31'b0, v}, {31'b0, ev});
    check($sformatf("fault_l%0d_t%0d", lat, tick), {31'b0, f}, {31'b0, ef});
    check($sformatf("inst_l%0d_t%0d", lat, tick), inst, last_m[k]);
  endtask

  task automatic check_all();
    check_dut(0, 1, inst1, v1, f1);
    check_dut(1, 3, inst3, v3, f3);
  endtask

  // One clock: check Ready, take the edge, update the model, check results.
  task automatic step();
    logic acc;
    logic flt;
    int   idx;
    #1;
    check("ready_l1", {31'b0, rdy1}, {31'b0, ~stall & ~ld_en});
    check("ready_l3", {31'b0, rdy3}, {31'b0, ~stall & ~ld_en});
    @(posedge clk);
    acc = rst_n && req && !stall && !ld_en;
    if (rst_n && !stall) begin
      idx = int'(addr >> 2);
      flt = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
      acc_v[tick] = acc;
      acc_f[tick] = acc && flt;
      acc_d[tick] = flt ? NOP : mem_m[idx % DEPTH];
      tick++;
    end
    if (ld_en && (ld_addr >> 2) < 32'(DEPTH)) mem_m[int'(ld_addr >> 2)] = ld_data;
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic s,
                       input logic l, input logic [31:0] la, input logic [31:0] ld);
    req = r; addr = a; stall = s; ld_en = l; ld_addr = la; ld_data = ld;
    step();
  endtask

  task automatic fetch(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 32'h0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    for (int i = 0; i < HIST; i++) begin
      acc_v[i] = 1'b0; acc_f[i] = 1'b0; acc_d[i] = 32'h0;
    end
    last_m[0] = 32'h0;
    last_m[1] = 32'h0;

    rst_n = 1'b0; req = 1'b0; addr = 32'h0; stall = 1'b0;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    #12;
    check_all();
    check("reset_ready", {31'b0, rdy1}, 32'h1);
    rst_n = 1'b1;

    // Preload every word so later reads never depend on power-up contents.
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), $urandom);
    load(32'h0, 32'h2001_0008);
    load(32'h4, 32'h3402_000C);
    load(32'h8, 32'h0022_1820);

    // Back-to-back fetches, then a lone fetch followed by bubbles.
    fetch(32'h0);
    fetch(32'h4);
    idle(4);
    fetch(32'h8);
    idle(4);

    // Misaligned and out-of-range, then a good one.
    fetch(32'h2);
    fetch(32'h80);
    fetch(32'h0);
    fetch(32'hFFFF_FFFC);
    fetch(32'h7F);
    idle(4);

    // Stream and stall while the first result is valid.
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(5);
    fetch(32'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h14, 32'h1234_5678);
    idle(4);

    // Load collides with a request: the request is dropped, next fetch sees new data.
    drive(1'b1, 32'hC, 1'b0, 1'b1, 32'hC, 32'hCAFE_F00D);
    fetch(32'hC);
    load(32'h8F, 32'hDEAD_BEEF);
    fetch(32'hC);
    fetch(32'h14);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 99) < 70) ra = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if ($urandom_range(0, 1) == 0) ra = 32'($urandom_range(0, DEPTH * 4 + 31));
      else ra = $urandom;
      drive($urandom_range(0, 99) < 70, ra, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 10, 32'($urandom_range(0, DEPTH * 4 + 15)), $urandom);
    end
    idle(4);

    // Asynchronous reset with fetches in flight.
    fetch(32'h0);
    fetch(32'h4);
    #2;
    rst_n = 1'b0;
    floor_t   = tick;
    last_m[0] = 32'h0;
    last_m[1] = 32'h0;
    #1;
    check_all();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    load(32'h10, 32'hA5A5_0010);
    idle(5);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'hC);
    fetch(32'h10);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_fetch.md
Name: inst_mem_fetch

Overview:
Parametrised, loadable instruction memory for the MIPS core. It replaces the fixed combinational ROM with a writable word array. A loader port fills the array, and reads go through a request/valid fetch pipeline of configurable latency. Fetch can be stalled by the consumer. Misaligned and out-of-range fetches are flagged. The block sits between the PC/fetch stage and the decode stage; the loader is driven by the testbench or boot logic.

Parameters:
ADDR_W, 32, byte-address width of Addr and LdAddr
DATA_W, 32, instruction word width
DEPTH, 32, number of words in the array (power of two, 2..1024)
LATENCY, 1, read pipeline depth in cycles from accepted Req to InstValid (1..4)
NOP_WORD, 32'h00000000, word returned on a faulting fetch

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Req  in  1  fetch request; sampled only when Ready=1
Addr  in  ADDR_W  fetch byte address
Ready  out  1  fetch can be accepted this cycle
Inst  out  DATA_W  fetched instruction
InstValid  out  1  Inst/Fault are valid this cycle
Fault  out  1  the returned fetch was misaligned or out of range
Stall  in  1  consumer hold; freezes the pipeline and outputs
LdEn  in  1  loader write enable
LdAddr  in  ADDR_W  loader byte address (word-aligned; bits [1:0] ignored)
LdData  in  DATA_W  loader write data

Behaviour:
- Reset (Rst_n=0, asynchronous): all pipeline valid bits are cleared. Inst=0, InstValid=0, Fault=0. Ready follows its combinational rule. Array contents are NOT cleared by reset and persist across it. At power-up the array is all zero.
- Ready = ~Stall & ~LdEn (combinational). A loader write blocks fetch acceptance in the same cycle.
- Accept: Req & Ready at a rising edge. The fetch enters stage 1.
  - With no stall, the fetch emerges with InstValid=1 exactly LATENCY edges after acceptance.
  - Back-to-back accepts give one result per cycle, in order.
- Stall=1: every stage, including Inst/InstValid/Fault, holds its value; no new fetch is accepted. Outputs are stable for the whole stall. When Stall drops, the pipeline advances on the next edge.
- Bubbles: a cycle with no accept inserts an invalid slot; InstValid=0 in the corresponding output cycle. In that cycle Inst holds its last value.
- Fault is decided at acceptance.
  - Misaligned when Addr[1:0]!=0.
  - Out of range when Addr[ADDR_W-1:2] >= DEPTH.
  - A faulting fetch returns Inst=NOP_WORD and Fault=1 with normal latency, and the array is not read. Fault=0 on every non-faulting result.
- Array read: word index Addr[clog2(DEPTH)+1:2]. The read is synchronous in stage 1; further stages are pure delay.
- Loader write: LdEn=1 at an edge writes LdData to word LdAddr[clog2(DEPTH)+1:2].
  - An out-of-range LdAddr (upper bits nonzero) is silently dropped.
  - Writes are allowed during Stall.
- Write/read ordering: a fetch accepted at edge N sees every write completed at or before edge N-1. No same-edge hazard exists, because Ready=0 whenever LdEn=1.
- Reset mid-operation: all in-flight fetches are discarded and produce no result. A write on the reset-release edge is honoured.
- Addr wrap: none. Indices at or above DEPTH always fault and never alias.

Decomposition:
- Shared package inst_mem_pkg:
  - NOP_WORD default constant.
  - Word-index width function clog2.
  - Typedef for the pipeline slot: valid, fault, data.
- Sub-module inst_mem_array: DEPTH x DATA_W storage with one synchronous write port and one synchronous read port with read enable. No reset on its contents.
- The top level holds the accept logic, fault decode, and the generate-loop delay stages (LATENCY-1 stages).

Test Plan:
1. Load 0x20010008 at 0x0 and 0x3402000C at 0x4, then Req Addr=0x0 and Addr=0x4 back-to-back (LATENCY=1) -> Inst=0x20010008 then 0x3402000C on consecutive cycles, InstValid=1, Fault=0.
2. LATENCY=3: Req Addr=0x8 (loaded 0x00221820) at edge N -> InstValid=1 and Inst=0x00221820 first at edge N+3, InstValid=0 at N+1 and N+2.
3. Req Addr=0x2, then Req Addr=0x80 with DEPTH=32 -> both results Fault=1, Inst=0x00000000. A following Req Addr=0x0 -> Fault=0.
4. Stream fetches 0x0, 0x4, 0x8 and assert Stall for 3 cycles while the first result is valid -> Inst/InstValid unchanged for 3 cycles, Ready=0. After release, the remaining results arrive in order with none lost or duplicated.
5. LdEn=1 with Req=1 in the same cycle -> Ready=0 and the Req is ignored. The next-cycle fetch of the same address returns the newly written word.
6. Assert Rst_n=0 with 2 fetches in flight (LATENCY=3) -> InstValid=0 and Fault=0 immediately (asynchronously). After release no stale result appears, and previously loaded words still read back correctly.
